udp_frame_send: RTL and testbench
=================================

# udp_frame_send

Reads a stored frame back out of DRAM one line segment at a time and packetizes it onto the UDP send stream (`w_req`/`w_enable`/`w_ack`/`w_data`). It is the transmit-side counterpart of the UDP-to-DRAM frame receiver: the same frame layout, one 32-bit word per pixel with RGB in [31:8], is read by address and sent as one packet per segment. It sits between the DRAM read port (`kick`/`busy`/`buf_we`) and the UDP stack's send FIFO, and uses the single system clock.

## Interface
- `X_SIZE`, 1600, pixels per line
- `Y_SIZE`, 900, lines per frame
- `SEG_PIXELS`, 400, pixels per packet; must divide `X_SIZE`; at most 1024
- `BASE_ADDR`, 32'h0, byte address of pixel (0,0)
- `clk`  in  1  system clock; reset is asynchronous and active-high
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins sending one frame
- `active`  out  1  high from `start` acceptance until the last packet word
- `frame_done`  out  1  one-cycle pulse after the last word of a frame
- `kick`  out  1  DRAM read request
- `busy`  in  1  DRAM read in progress
- `read_addr`  out  32  byte address of the read
- `read_num`  out  32  number of 32-bit words to read
- `buf_dout`  in  32  read data word
- `buf_we`  in  1  `buf_dout` valid
- `w_req`  out  1  packet ready to send
- `w_ack`  in  1  send grant
- `w_enable`  out  1  `w_data` valid
- `w_data`  out  32  packet word

## Operation
- States: IDLE, KICK, FILL, REQ, SEND, NEXT.
- IDLE: `start`=1 loads y=0, seg=0, moves to KICK and sets `active`. `start` is ignored in every other state.
- KICK:
  - `kick`=1, `read_addr`=`BASE_ADDR`+((y*`X_SIZE`+seg*`SEG_PIXELS`)<<2), `read_num`=`SEG_PIXELS`.
  - Arithmetic is done in 32 bits.
  - The request is accepted on the first cycle with `kick`&&`busy`; `kick` drops the next cycle and the state moves to FILL.
- FILL:
  - Each `buf_we` writes `buf_dout` into the local buffer at wcnt, and wcnt increments.
  - Writes with wcnt ≥ `SEG_PIXELS` are discarded.
  - FILL exits to REQ when `busy`=0 and wcnt=`SEG_PIXELS`.
  - If `busy`=0 with wcnt<`SEG_PIXELS`, the block re-kicks the same segment (back to KICK, wcnt=0).
- REQ: `w_req`=1 until `w_ack` is sampled high, then SEND.
- SEND: `w_enable`=1 for exactly N consecutive cycles, with no backpressure.
  - Word 0 (header) = {8'hA5, frame_id[7:0], y[11:0], seg[3:0]}.
  - Words 1..`SEG_PIXELS` = {buf[i][31:8], 8'h00}.
- NEXT:
  - seg increments; at the last segment, seg=0 and y increments.
  - If y = `Y_SIZE`-1 and the last segment has just been sent, `frame_done` pulses, frame_id increments (wraps 255→0), `active` drops, and the state goes to IDLE.
  - Otherwise the state goes to KICK.
- N = `SEG_PIXELS`+1, or +2 with the checksum (see Configuration).

## Timing
- Reset values: all outputs 0; frame_id=0; state IDLE. Reset is asynchronous mid-operation.
- After reset, stray `busy`/`buf_we` from an aborted read are ignored in IDLE.
- `start` sampled at edge t: `kick`=1 and `active`=1 from t+1.
- `busy` and `buf_we` are registered-domain inputs sampled directly. `kick`&&`busy` at edge t gives `kick`=0 at t+1.
- `w_req` rises on the cycle after FILL completes.
- `w_ack` sampled at edge t gives `w_req`=0 and `w_enable`=1 (header) from t+1; the last word is at t+N.
- `w_ack` is ignored outside REQ.
- `frame_done` is high for one cycle, at t+N+1.
- The local buffer is single-ported in each direction; FILL and SEND never overlap (no ping-pong).
- `w_data` holds its last value when `w_enable`=0; it is don't-care for checking.

## Configuration
- `UDP_FRAME_SEND_CSUM_EN` defined:
  - A trailer word is appended after the payload, making N=`SEG_PIXELS`+2.
  - Trailer = 32-bit wrap-around sum of payload words 1..`SEG_PIXELS` as transmitted (low byte zero). The header is excluded.
- Not defined: no trailer, N=`SEG_PIXELS`+1, and no sum logic is present.

## Test plan
Use `X_SIZE`=8, `Y_SIZE`=2, `SEG_PIXELS`=4, `BASE_ADDR`=32'h1000 unless noted.
- Basic frame:
  - Stimulus: `start`; DRAM model returns words 0x01020300+k.
  - Required: 4 packets with `read_addr` 0x1000, 0x1010, 0x1020, 0x1030.
  - Headers 0xA5000000, 0xA5000001, 0xA5000010, 0xA5000011; `frame_done` once; `active` low after.
- Grant delay: `w_ack` held off 20 cycles -> `w_req` stays high 20 cycles, no `w_enable`; header appears exactly 1 cycle after `w_ack`.
- Short read: model gives 3 `buf_we` then drops `busy` -> second `kick` with the same `read_addr`; the packet carries only the second read's 4 words.
- Overflow plus `start` during active: model gives 6 `buf_we`, and `start` pulses mid-frame -> only the first 4 words are sent; no restart; frame_id unchanged until `frame_done`.
- Frame id wrap plus reset:
  - 256 frames -> frame 257's header frame_id = 0x00.
  - Assert `rst` during SEND -> all outputs 0 immediately; the next `start` sends y=0, seg=0.
- Checksum, with `UDP_FRAME_SEND_CSUM_EN` defined: payload {0x00000100, 0x00000200, 0x00000300, 0xFFFFFF00} -> trailer 0x00000500; `w_enable` high 6 cycles.

Source files
------------

// File: rtl/udp_frame_send_if.sv
// DRAM read-port and UDP send-stream signals of udp_frame_send.
// master = frame sender, slave = DRAM reader plus UDP stack.
interface udp_frame_send_if;
    logic        kick;
    logic        busy;
    logic [31:0] read_addr;
    logic [31:0] read_num;
    logic [31:0] buf_dout;
    logic        buf_we;
    logic        w_req;
    logic        w_ack;
    logic        w_enable;
    logic [31:0] w_data;

    modport master (
        output kick, read_addr, read_num, w_req, w_enable, w_data,
        input  busy, buf_dout, buf_we, w_ack
    );

    modport slave (
        input  kick, read_addr, read_num, w_req, w_enable, w_data,
        output busy, buf_dout, buf_we, w_ack
    );
endinterface

// File: rtl/udp_frame_send.sv
// udp_frame_send: reads a frame from DRAM one line segment at a time and sends one UDP packet per segment.
// Define UDP_FRAME_SEND_CSUM_EN to append a wrap-around payload sum trailer to every packet.
module udp_frame_send #(
    parameter int          X_SIZE     = 1600,
    parameter int          Y_SIZE     = 900,
    parameter int          SEG_PIXELS = 400,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic active,
    output logic frame_done,
    udp_frame_send_if.master bus
);
    localparam int NSEG = X_SIZE / SEG_PIXELS;
    localparam int SW   = (NSEG > 16) ? $clog2(NSEG) : 4;
    localparam int AW   = (SEG_PIXELS > 1) ? $clog2(SEG_PIXELS) : 1;
    localparam int CW   = $clog2(SEG_PIXELS + 3);
    localparam logic [CW-1:0] SEG_C    = CW'(SEG_PIXELS);
    localparam logic [SW-1:0] LAST_SEG = SW'(NSEG - 1);
    localparam logic [11:0]   LAST_Y   = 12'(Y_SIZE - 1);

    typedef enum logic [2:0] {IDLE, KICK, FILL, REQ, SEND, NEXT} state_t;

    state_t          state;
    logic [11:0]     y;
    logic [SW-1:0]   seg;
    logic [7:0]      frame_id;
    logic [CW-1:0]   wcnt;
    logic [CW-1:0]   rcnt;
    logic [AW-1:0]   rd_ptr;
    logic [31:0]     seg_buf [SEG_PIXELS];
    logic [31:0]     payload;
    logic            buf_wr;
`ifdef UDP_FRAME_SEND_CSUM_EN
    logic [31:0]     sum;
`endif

    function automatic logic [31:0] seg_addr(input logic [11:0] yy, input logic [SW-1:0] ss);
        return BASE_ADDR + ((32'(yy) * 32'(X_SIZE) + 32'(ss) * 32'(SEG_PIXELS)) << 2);
    endfunction

    // Beats past the segment length are dropped so an over-long read cannot corrupt the buffer.
    assign buf_wr  = (state == FILL) && bus.buf_we && (wcnt < SEG_C);
    assign payload = seg_buf[rd_ptr] & 32'hFFFF_FF00;

    always_ff @(posedge clk) begin
        if (buf_wr) seg_buf[wcnt[AW-1:0]] <= bus.buf_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            y             <= '0;
            seg           <= '0;
            frame_id      <= '0;
            wcnt          <= '0;
            rcnt          <= '0;
            rd_ptr        <= '0;
            active        <= 1'b0;
            frame_done    <= 1'b0;
            bus.kick      <= 1'b0;
            bus.read_addr <= '0;
            bus.read_num  <= '0;
            bus.w_req     <= 1'b0;
            bus.w_enable  <= 1'b0;
            bus.w_data    <= '0;
`ifdef UDP_FRAME_SEND_CSUM_EN
            sum           <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    y             <= '0;
                    seg           <= '0;
                    bus.read_addr <= BASE_ADDR;
                    bus.read_num  <= 32'(SEG_PIXELS);
                    bus.kick      <= 1'b1;
                    active        <= 1'b1;
                    state         <= KICK;
                end
                KICK: if (bus.busy) begin
                    bus.kick <= 1'b0;
                    wcnt     <= '0;
                    state    <= FILL;
                end
                FILL: begin
                    if (buf_wr) wcnt <= wcnt + CW'(1);
                    // A read that ends short is retried from scratch for the same segment.
                    if (!bus.busy) begin
                        if (wcnt == SEG_C) begin
                            bus.w_req <= 1'b1;
                            state     <= REQ;
                        end else begin
                            bus.kick <= 1'b1;
                            state    <= KICK;
                        end
                    end
                end
                REQ: if (bus.w_ack) begin
                    bus.w_req    <= 1'b0;
                    bus.w_enable <= 1'b1;
                    bus.w_data   <= {8'hA5, frame_id, y, seg[3:0]};
                    rcnt         <= CW'(1);
                    rd_ptr       <= '0;
`ifdef UDP_FRAME_SEND_CSUM_EN
                    sum          <= '0;
`endif
                    state        <= SEND;
                end
                SEND: begin
                    if (rcnt <= SEG_C) begin
                        bus.w_data <= payload;
                        rd_ptr     <= rd_ptr + AW'(1);
                        rcnt       <= rcnt + CW'(1);
`ifdef UDP_FRAME_SEND_CSUM_EN
                        sum        <= sum + payload;
                    end else if (rcnt == SEG_C + CW'(1)) begin
                        bus.w_data <= sum;
                        rcnt       <= rcnt + CW'(1);
`endif
                    end else begin
                        bus.w_enable <= 1'b0;
                        if (seg == LAST_SEG) begin
                            seg <= '0;
                            if (y == LAST_Y) begin
                                y          <= '0;
                                frame_done <= 1'b1;
                                frame_id   <= frame_id + 8'd1;
                                active     <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                y     <= y + 12'd1;
                                state <= NEXT;
                            end
                        end else begin
                            seg   <= seg + SW'(1);
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    bus.read_addr <= seg_addr(y, seg);
                    bus.kick      <= 1'b1;
                    state         <= KICK;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_frame_send.sv
// Randomized bench for udp_frame_send: DRAM and UDP-stack models plus a packet-level reference model.
module tb_udp_frame_send;
    localparam int X = 8, Y = 2, SEG = 4;
    localparam logic [31:0] BASE = 32'h1000;
`ifdef UDP_FRAME_SEND_CSUM_EN
    localparam int N = SEG + 2;
`else
    localparam int N = SEG + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic active, frame_done;
    udp_frame_send_if bus();

    udp_frame_send #(.X_SIZE(X), .Y_SIZE(Y), .SEG_PIXELS(SEG), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .active(active), .frame_done(frame_done), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int fid_m = 0;
    int done_cnt = 0, done_exp = 0;
    int pat = 0;          // 0 random data, 1 ramp 0x01020300+k, 2 checksum vector
    bit fast = 1'b0;
    logic [31:0] exp_words[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Packet stream compare against the model queue, every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.w_enable) begin
                if (exp_words.size() == 0) check_bit("w_enable_unexpected", bus.w_enable, 1'b0);
                else check("w_data", bus.w_data, exp_words.pop_front());
            end
            if (frame_done) begin
                done_cnt++;
                check_bit("active_at_done", active, 1'b0);
            end
            if (bus.kick || bus.w_req || bus.w_enable) check_bit("active_while_working", active, 1'b1);
        end
    end

    task automatic wait_kick();
        int t = 0;
        while (!bus.kick && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.kick) check_bit("kick_timeout", bus.kick, 1'b1);
    endtask

    task automatic serve_segment(input int y, input int s, input int mode, input int ack_dly,
                                 input int abort_at, input bit lit,
                                 input logic [31:0] lit_addr, input logic [31:0] lit_hdr);
        logic [31:0] data [SEG];
        logic [31:0] cv [4];
        logic [31:0] exp_addr, d, sum, hdr;
        int attempts, nbeats;
        bit last;
        cv = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'hFFFF_FF00};
        exp_addr = BASE + ((y * X + s * SEG) << 2);
        attempts = (mode == 1) ? 2 : 1;
        for (int a = 0; a < attempts; a++) begin
            wait_kick();
            check("read_addr", bus.read_addr, exp_addr);
            if (lit) check("read_addr_lit", bus.read_addr, lit_addr);
            check("read_num", bus.read_num, SEG);
            repeat (fast ? 0 : $urandom_range(0, 2)) @(negedge clk);
            bus.busy = 1'b1;
            @(negedge clk);
            check_bit("kick_drop", bus.kick, 1'b0);
            nbeats = (mode == 1 && a == 0) ? 3 : ((mode == 2) ? 6 : SEG);
            for (int k = 0; k < nbeats; k++) begin
                case (pat)
                    1: d = 32'h0102_0300 + k;
                    2: d = cv[k % 4];
                    default: d = $urandom();
                endcase
                if (k < SEG) data[k] = d;
                bus.buf_we = 1'b1;
                bus.buf_dout = d;
                if (mode == 2) begin
                    start = (k == 2);
                    bus.w_ack = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                bus.buf_we = 1'b0;
                start = 1'b0;
                bus.w_ack = 1'b0;
                if (!fast && $urandom_range(0, 3) == 0) @(negedge clk);
            end
            bus.busy = 1'b0;
            @(negedge clk);
        end

        hdr = {8'hA5, 8'(fid_m), 12'(y), 4'(s)};
        exp_words.push_back(hdr);
        sum = '0;
        for (int k = 0; k < SEG; k++) begin
            exp_words.push_back(data[k] & 32'hFFFF_FF00);
            sum += data[k] & 32'hFFFF_FF00;
        end
`ifdef UDP_FRAME_SEND_CSUM_EN
        exp_words.push_back(sum);
`endif

        check_bit("w_req_rise", bus.w_req, 1'b1);
        for (int i = 0; i < ack_dly; i++) begin
            check_bit("w_req_hold", bus.w_req, 1'b1);
            check_bit("no_w_enable_before_ack", bus.w_enable, 1'b0);
            @(negedge clk);
        end
        bus.w_ack = 1'b1;
        @(negedge clk);
        bus.w_ack = 1'b0;
        check_bit("hdr_after_ack", bus.w_enable, 1'b1);
        check_bit("w_req_drop", bus.w_req, 1'b0);
        if (lit) check("hdr_lit", bus.w_data, lit_hdr);
        for (int i = 1; i < N; i++) begin
            if (i == abort_at) return;
            @(negedge clk);
            check_bit("w_enable_burst", bus.w_enable, 1'b1);
`ifdef UDP_FRAME_SEND_CSUM_EN
            if (pat == 2 && i == N - 1) check("trailer_lit", bus.w_data, 32'h0000_0500);
`endif
        end
        @(negedge clk);
        check_bit("w_enable_end", bus.w_enable, 1'b0);
        last = (s == X / SEG - 1) && (y == Y - 1);
        check_bit("frame_done_pulse", frame_done, last);
        check_bit("active_after_packet", active, !last);
        if (last) begin
            done_exp++;
            fid_m = (fid_m + 1) % 256;
            @(negedge clk);
            check_bit("frame_done_one_cycle", frame_done, 1'b0);
        end
    endtask

    task automatic run_frame(input int mode, input int ack_dly, input bit lit);
        logic [31:0] la [4];
        logic [31:0] lh [4];
        la = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
        lh = '{32'hA500_0000, 32'hA500_0001, 32'hA500_0010, 32'hA500_0011};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_bit("kick_after_start", bus.kick, 1'b1);
        check_bit("active_after_start", active, 1'b1);
        for (int y = 0; y < Y; y++)
            for (int s = 0; s < X / SEG; s++)
                serve_segment(y, s, (mode < 0) ? int'($urandom_range(0, 2)) : mode,
                              (ack_dly < 0) ? int'($urandom_range(0, 5)) : ack_dly,
                              -1, lit, la[y * 2 + s], lh[y * 2 + s]);
        repeat (3) begin
            @(negedge clk);
            check_bit("idle_no_kick", bus.kick, 1'b0);
            check_bit("idle_inactive", active, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        bus.busy = 1'b0;
        bus.buf_we = 1'b0;
        bus.buf_dout = '0;
        bus.w_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("rst_kick", bus.kick, 1'b0);
        check_bit("rst_w_req", bus.w_req, 1'b0);
        check_bit("rst_w_enable", bus.w_enable, 1'b0);
        check_bit("rst_active", active, 1'b0);
        check_bit("rst_frame_done", frame_done, 1'b0);
        check("rst_read_addr", bus.read_addr, 32'h0);
        check("rst_read_num", bus.read_num, 32'h0);
        check("rst_w_data", bus.w_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        pat = 1; run_frame(0, 2, 1'b1);      // basic frame with literal addresses/headers
        pat = 0; run_frame(0, 20, 1'b0);     // long grant delay
        run_frame(1, 1, 1'b0);               // short reads
        run_frame(2, 0, 1'b0);               // overflow reads, stray start and w_ack
`ifdef UDP_FRAME_SEND_CSUM_EN
        pat = 2; run_frame(0, 0, 1'b0);
        pat = 0;
`endif
        repeat (6) run_frame(-1, -1, 1'b0);
        fast = 1'b1;
        while (fid_m != 0) run_frame(0, 0, 1'b0);
        fast = 1'b0;
        run_frame(-1, 1, 1'b1);              // frame 257: frame_id back to 0x00

        // Reset in the middle of a packet, with a stray read still in flight.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve_segment(0, 0, 0, 0, 2, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check_bit("arst_kick", bus.kick, 1'b0);
        check_bit("arst_w_req", bus.w_req, 1'b0);
        check_bit("arst_w_enable", bus.w_enable, 1'b0);
        check_bit("arst_active", active, 1'b0);
        check_bit("arst_frame_done", frame_done, 1'b0);
        check("arst_read_addr", bus.read_addr, 32'h0);
        check("arst_read_num", bus.read_num, 32'h0);
        check("arst_w_data", bus.w_data, 32'h0);
        exp_words.delete();
        fid_m = 0;
        @(negedge clk);
        bus.busy = 1'b1;
        bus.buf_we = 1'b1;
        bus.buf_dout = $urandom();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_bit("stray_no_kick", bus.kick, 1'b0);
            check_bit("stray_inactive", active, 1'b0);
            check_bit("stray_no_w_req", bus.w_req, 1'b0);
        end
        bus.busy = 1'b0;
        bus.buf_we = 1'b0;
        @(negedge clk);
        run_frame(0, 1, 1'b1);

        check("frame_done_count", done_cnt, done_exp);
        check("leftover_words", exp_words.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
